// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding,
// odd-parity helper and 50 MHz default timing constants.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_START     = 3'd3,
    ST_DATA      = 3'd4,
    ST_ACK       = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } ps2_state_e;

  // 120 us clock-low request hold at 50 MHz
  localparam int PS2_INHIBIT_CYCLES     = 6000;
  // 15 ms for the device to start clocking
  localparam int PS2_FIRST_EDGE_TIMEOUT = 750000;
  // 2 ms between device clock edges and for the bus to go idle
  localparam int PS2_BIT_TIMEOUT        = 100000;
  // extra attempts when retries are built in
  localparam int PS2_MAX_RETRY          = 2;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a
// falling-edge strobe on the synchronized clock. The strobe is valid in
// the third cycle after the pin changes. Idle bus level (1) on reset.
`timescale 1ns/1ps
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_clk_fall
);

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;

  // bring both pins into the system clock domain and keep the previous clock level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_dat;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign o_clk_sync = r_clk_s2;
  assign o_dat_sync = r_dat_s2;
  assign o_clk_fall = r_clk_prev & ~r_clk_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the
// host-request sequence and drives the open-drain pins via output enables.
// Optional macro PS2_TX_RETRY_EN: retry a failed byte up to MAX_RETRY
// times before reporting ERROR.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES     = PS2_INHIBIT_CYCLES,
  parameter int FIRST_EDGE_TIMEOUT = PS2_FIRST_EDGE_TIMEOUT,
  parameter int BIT_TIMEOUT        = PS2_BIT_TIMEOUT
`ifdef PS2_TX_RETRY_EN
  , parameter int MAX_RETRY        = PS2_MAX_RETRY
`endif
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE
);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_INHIBIT   = ST_INHIBIT;
  localparam logic [2:0] S_REQ       = ST_REQ;
  localparam logic [2:0] S_START     = ST_START;
  localparam logic [2:0] S_DATA      = ST_DATA;
  localparam logic [2:0] S_ACK       = ST_ACK;
  localparam logic [2:0] S_WAIT_IDLE = ST_WAIT_IDLE;

  // one down-counter serves both the inhibit hold and the timeouts
  localparam int CW = $clog2(max_of3(INHIBIT_CYCLES, FIRST_EDGE_TIMEOUT, BIT_TIMEOUT) + 1);

  logic w_clk_sync, w_dat_sync, w_clk_fall;
  logic w_timed, w_tmo, w_nack, w_fail, w_tx_bit;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bits;
  logic [7:0]    r_byte;
  logic          r_parity;
  logic          r_busy, r_done, r_error, r_clk_oe, r_dat_oe;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    r_attempt;
`endif

  ps2_sync_edge u_sync (
    .i_clk      (CLOCK),
    .i_rst_n    (RESET_N),
    .i_ps2_clk  (PS2_CLK_IN),
    .i_ps2_dat  (PS2_DAT_IN),
    .o_clk_sync (w_clk_sync),
    .o_dat_sync (w_dat_sync),
    .o_clk_fall (w_clk_fall)
  );

  // failure detection and selection of the next bit to present on the data line
  always_comb begin
    w_timed = (r_state == S_START) || (r_state == S_DATA) ||
              (r_state == S_ACK)   || (r_state == S_WAIT_IDLE);
    w_tmo = 1'b0;
    if (w_timed && (r_cnt == {CW{1'b0}})) begin
      // the awaited event in the expiry cycle still wins over the timeout
      if (r_state == S_WAIT_IDLE) begin
        w_tmo = ~(w_clk_sync & w_dat_sync);
      end else begin
        w_tmo = ~w_clk_fall;
      end
    end else begin
      w_tmo = 1'b0;
    end
    w_nack = (r_state == S_ACK) & w_clk_fall & w_dat_sync;
    w_fail = w_tmo | w_nack;
    if (r_bits[3]) begin
      w_tx_bit = r_parity;
    end else begin
      w_tx_bit = r_byte[r_bits[2:0]];
    end
  end

  // transmit sequencer: request, shift bits on device falling edges, check ACK, wait for idle
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_bits    <= 4'd0;
      r_byte    <= 8'd0;
      r_parity  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_attempt <= 2'd0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_fail) begin
        r_clk_oe <= 1'b0;
        r_dat_oe <= 1'b0;
        r_bits   <= 4'd0;
`ifdef PS2_TX_RETRY_EN
        if (r_attempt < 2'(MAX_RETRY)) begin
          // start over with the same latched byte; BUSY stays high
          r_attempt <= r_attempt + 2'd1;
          r_state   <= S_INHIBIT;
          r_clk_oe  <= 1'b1;
          r_cnt     <= CW'(INHIBIT_CYCLES - 1);
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_error <= 1'b1;
          r_cnt   <= {CW{1'b0}};
        end
`else
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_error <= 1'b1;
        r_cnt   <= {CW{1'b0}};
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            // a request landing on the DONE/ERROR cycle is dropped
            if (TX_START && !r_done && !r_error) begin
              r_byte    <= TX_DATA;
              r_parity  <= odd_parity(TX_DATA);
              r_busy    <= 1'b1;
              r_clk_oe  <= 1'b1;
              r_bits    <= 4'd0;
              r_cnt     <= CW'(INHIBIT_CYCLES - 1);
              r_state   <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              r_attempt <= 2'd0;
`endif
            end
          end
          S_INHIBIT: begin
            if (r_cnt == {CW{1'b0}}) begin
              r_dat_oe <= 1'b1;
              r_state  <= S_REQ;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_REQ: begin
            // release clock, keep the start bit driven low
            r_clk_oe <= 1'b0;
            r_cnt    <= CW'(FIRST_EDGE_TIMEOUT - 1);
            r_state  <= S_START;
          end
          S_START, S_DATA: begin
            if (w_clk_fall) begin
              r_cnt  <= CW'(BIT_TIMEOUT - 1);
              r_bits <= r_bits + 4'd1;
              if (r_bits == 4'd9) begin
                // tenth edge: let the stop bit float high
                r_dat_oe <= 1'b0;
                r_state  <= S_ACK;
              end else begin
                r_dat_oe <= ~w_tx_bit;
                r_state  <= S_DATA;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_ACK: begin
            // a high ACK is caught as a failure above
            if (w_clk_fall) begin
              r_cnt   <= CW'(BIT_TIMEOUT - 1);
              r_state <= S_WAIT_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_WAIT_IDLE: begin
            if (w_clk_sync && w_dat_sync) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_cnt   <= {CW{1'b0}};
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_cnt    <= {CW{1'b0}};
          end
        endcase
      end
    end
  end

  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERROR      = r_error;
  assign PS2_CLK_OE = r_clk_oe;
  assign PS2_DAT_OE = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a PS/2 device model and scaled-down timing.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int FET  = 600;
  localparam int BITT = 200;
  localparam int HALF = 12;
`ifdef PS2_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_START = 1'b0;
  logic       BUSY, DONE, ERROR, PS2_CLK_OE, PS2_DAT_OE;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       w_ps2_clk, w_ps2_dat;

  assign w_ps2_clk = dev_clk & ~PS2_CLK_OE;
  assign w_ps2_dat = dev_dat & ~PS2_DAT_OE;

  ps2_host_tx #(
    .INHIBIT_CYCLES     (INH),
    .FIRST_EDGE_TIMEOUT (FET),
    .BIT_TIMEOUT        (BITT)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .TX_DATA    (TX_DATA),
    .TX_START   (TX_START),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .PS2_CLK_IN (w_ps2_clk),
    .PS2_DAT_IN (w_ps2_dat),
    .PS2_CLK_OE (PS2_CLK_OE),
    .PS2_DAT_OE (PS2_DAT_OE)
  );

  always #10 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_mis = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int inh_run = 0;
  int inh_q[$];

  // pulse counters and lengths of each clock-inhibit phase (clock pulled, data free)
  always @(negedge CLOCK) begin
    if (DONE) n_done++;
    if (ERROR) n_err++;
    if (DONE && ERROR) n_both++;
    if (PS2_CLK_OE && !PS2_DAT_OE) inh_run++;
    else if (inh_run != 0) begin
      inh_q.push_back(inh_run);
      inh_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference frame as the device sees it: 8 data bits LSB first, odd parity, stop
  function automatic logic [9:0] frame_model(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic host_send(input logic [7:0] b);
    @(negedge CLOCK);
    TX_DATA = b;
    TX_START = 1'b1;
    @(negedge CLOCK);
    TX_START = 1'b0;
    check("busy_rise", {31'd0, BUSY}, 32'd1);
  endtask

  // device side of one attempt: wait for the request, then clock out n_edges edges
  task automatic device_xfer(input string tag, input int n_edges, input logic ack,
                             output logic [9:0] frame);
    int guard = 0;
    frame = 10'h000;
    while (!(PS2_CLK_OE && PS2_DAT_OE) && guard < 3000) begin
      @(negedge CLOCK);
      guard++;
    end
    check({tag, "/req_seen"}, {31'd0, (guard < 3000)}, 32'd1);
    @(negedge CLOCK);
    check({tag, "/start_phase"}, {29'd0, PS2_CLK_OE, PS2_DAT_OE, w_ps2_dat}, 32'b010);
    if (n_edges > 0) repeat (4) @(negedge CLOCK);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) begin
        dev_dat = ~ack;
        repeat (4) @(negedge CLOCK);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK);
      dev_clk = 1'b1;
      if (e <= 10) frame[e-1] = w_ps2_dat;
      repeat (HALF) @(negedge CLOCK);
      if (e == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic wait_end(input logic poke, output logic saw_done, output logic saw_err);
    saw_done = 1'b0;
    saw_err = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLOCK);
      if (DONE || ERROR) begin
        saw_done = DONE;
        saw_err = ERROR;
        if (poke) begin
          TX_DATA = 8'hA5;
          TX_START = 1'b1;
          @(negedge CLOCK);
          TX_START = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [7:0] b, input logic ack,
                         input logic poke, input logic intrude, input logic [9:0] exp_frame);
    int d0, e0, attempts;
    logic sd, se;
    logic [9:0] fr;
    attempts = ack ? 1 : (1 + RETRIES);
    inh_q.delete();
    d0 = n_done;
    e0 = n_err;
    host_send(b);
    if (intrude) begin
      repeat (5) @(negedge CLOCK);
      TX_DATA = 8'h55;
      TX_START = 1'b1;
      @(negedge CLOCK);
      TX_START = 1'b0;
    end
    fork
      begin
        for (int a = 0; a < attempts; a++) begin
          device_xfer(tag, 11, ack, fr);
          check({tag, "/frame"}, {22'd0, fr}, {22'd0, exp_frame});
        end
      end
      wait_end(poke, sd, se);
    join
    check({tag, "/done_seen"}, {31'd0, sd}, {31'd0, ack});
    check({tag, "/error_seen"}, {31'd0, se}, {31'd0, ~ack});
    repeat (3) @(negedge CLOCK);
    check({tag, "/idle_after"}, {29'd0, BUSY, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
    check({tag, "/done_count"}, n_done - d0, ack ? 32'd1 : 32'd0);
    check({tag, "/error_count"}, n_err - e0, ack ? 32'd0 : 32'd1);
    check({tag, "/inhibit_phases"}, inh_q.size(), attempts);
    foreach (inh_q[k]) check({tag, "/inhibit_len"}, inh_q[k], INH);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       poke;
    logic [9:0] exp_frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0, cnt;
    logic [7:0] rb;
    logic ra, rp;
    logic [9:0] fr;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 10'h3ED};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 10'h201};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 10'h300};
    vecs[3] = '{8'hED, 1'b0, 1'b0, 10'h3ED};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 10'h280};

    // reset state
    repeat (3) @(negedge CLOCK);
    check("reset_outputs", {27'd0, BUSY, DONE, ERROR, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK);

    // table-driven transfers
    for (int i = 0; i < 5; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, vecs[i].poke, 1'b0,
              vecs[i].exp_frame);

    // request while busy is ignored; 0xFF goes through unchanged
    run_vec("busy_ignore", 8'hFF, 1'b1, 1'b0, 1'b1, 10'h3FF);

    // device never clocks: each attempt times out FET cycles after START entry
    inh_q.delete();
    e0 = n_err;
    d0 = n_done;
    host_send(8'hED);
    for (int a = 0; a <= RETRIES; a++) begin
      device_xfer("no_clock", 0, 1'b1, fr);
      cnt = 0;
      do begin
        @(negedge CLOCK);
        cnt++;
      end while (!(ERROR || PS2_CLK_OE) && cnt < 2 * FET);
      check("no_clock/timeout_cycles", cnt, FET);
    end
    repeat (2) @(negedge CLOCK);
    check("no_clock/error_count", n_err - e0, 32'd1);
    check("no_clock/done_count", n_done - d0, 32'd0);
    check("no_clock/released", {29'd0, BUSY, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
    check("no_clock/inhibit_phases", inh_q.size(), 1 + RETRIES);

    // reset mid-transfer at edge 5, then a clean 0xF4
    d0 = n_done;
    e0 = n_err;
    host_send(8'h3C);
    device_xfer("mid_reset", 5, 1'b1, fr);
    repeat (4) @(negedge CLOCK);
    check("mid_reset/busy_before", {31'd0, BUSY}, 32'd1);
    #3 RESET_N = 1'b0;
    #1 check("mid_reset/async_release", {28'd0, BUSY, DONE, ERROR, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("mid_reset/no_pulses", (n_done - d0) + (n_err - e0), 32'd0);
    run_vec("after_reset", 8'hF4, 1'b1, 1'b0, 1'b0, 10'h2F4);

    // randomized bytes and ACK behaviour against the frame model
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d_%02h", i, rb), rb, ra, rp, 1'b0, frame_model(rb));
    end

    check("done_error_exclusive", n_both, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
